// File: rtl/debug_ctrlr.sv
// Debug command executor: runs pause/resume/reset, memory and register-file
// commands decoded by the serial front end against the RISC-V core.
module debug_ctrlr #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RESET_HOLD     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic        out_valid,
    output logic        ctrlr_busy,
    output logic [31:0] d_rd,
    output logic        error,
    output logic        cpu_pause,
    output logic        cpu_reset,
    input  logic        cpu_halted,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > RESET_HOLD) ? TIMEOUT_CYCLES : RESET_HOLD;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 8) ? $clog2(CNT_MAX + 1) : 8;

    localparam logic [3:0] CMD_PAUSE     = 4'h1;
    localparam logic [3:0] CMD_RESUME    = 4'h2;
    localparam logic [3:0] CMD_STATUS    = 4'h3;
    localparam logic [3:0] CMD_CPU_RESET = 4'h4;
    localparam logic [3:0] CMD_MEM_RD_W  = 4'h5;
    localparam logic [3:0] CMD_MEM_WR_W  = 4'h6;
    localparam logic [3:0] CMD_MEM_RD_B  = 4'h7;
    localparam logic [3:0] CMD_MEM_WR_B  = 4'h8;
    localparam logic [3:0] CMD_REG_RD    = 4'h9;
    localparam logic [3:0] CMD_REG_WR    = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_HALT,
        S_MEM_WAIT,
        S_REG_RD,
        S_RST_HOLD,
        S_DONE
    } state_e;

    state_e            state;
    logic [3:0]        cmd_q;
    logic [31:0]       addr_q;
    logic [31:0]       din_q;
    logic [CNT_W-1:0]  cnt;

    logic       is_word;
    logic       is_write;
    logic       mem_addr_ok;
    logic       reg_addr_ok;
    logic       tmo_hit;
    logic [7:0] rd_byte;

    assign is_word     = (cmd_q == CMD_MEM_RD_W) || (cmd_q == CMD_MEM_WR_W);
    assign is_write    = (cmd_q == CMD_MEM_WR_W) || (cmd_q == CMD_MEM_WR_B);
    assign mem_addr_ok = !is_word || (addr_q[1:0] == 2'b00);
    assign reg_addr_ok = (addr_q[31:5] == 27'd0);
    assign tmo_hit     = (cnt == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
    end

    // NOTE: rf_we is decoded from the state rather than registered, so the halt
    // check made in EXEC can still suppress it and an async reset kills it at once.
    assign rf_we    = (state == S_EXEC) && (cmd_q == CMD_REG_WR) && cpu_halted && reg_addr_ok;
    assign rf_addr  = addr_q[4:0];
    assign rf_wdata = din_q;

    // NOTE: every register here is state, so only non-blocking assignments appear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            cnt        <= '0;
            ctrlr_busy <= 1'b0;
            d_rd       <= '0;
            error      <= 1'b0;
            cpu_pause  <= 1'b0;
            cpu_reset  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (out_valid) begin
                        cmd_q      <= cmd;
                        addr_q     <= addr;
                        din_q      <= d_in;
                        error      <= 1'b0;
                        ctrlr_busy <= 1'b1;
                        state      <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (cmd_q)
                        CMD_PAUSE: begin
                            cpu_pause <= 1'b1;
                            cnt       <= '0;
                            state     <= S_WAIT_HALT;
                        end
                        CMD_RESUME: begin
                            cpu_pause <= 1'b0;
                            d_rd      <= '0;
                            state     <= S_DONE;
                        end
                        CMD_STATUS: begin
                            d_rd  <= {30'd0, cpu_pause, cpu_halted};
                            state <= S_DONE;
                        end
                        CMD_CPU_RESET: begin
                            cpu_reset <= 1'b1;
                            cnt       <= '0;
                            state     <= S_RST_HOLD;
                        end
                        CMD_MEM_RD_W, CMD_MEM_WR_W, CMD_MEM_RD_B, CMD_MEM_WR_B: begin
                            if (!cpu_halted || !mem_addr_ok) begin
                                error <= 1'b1;
                                d_rd  <= '0;
                                state <= S_DONE;
                            end else begin
                                mem_req   <= 1'b1;
                                mem_we    <= is_write;
                                mem_be    <= is_word ? 4'hF : (4'b0001 << addr_q[1:0]);
                                mem_addr  <= addr_q;
                                mem_wdata <= is_word ? din_q : {4{din_q[7:0]}};
                                cnt       <= '0;
                                state     <= S_MEM_WAIT;
                            end
                        end
                        CMD_REG_RD, CMD_REG_WR: begin
                            if (!cpu_halted || !reg_addr_ok) begin
                                error <= 1'b1;
                                d_rd  <= '0;
                                state <= S_DONE;
                            end else if (cmd_q == CMD_REG_RD) begin
                                state <= S_REG_RD;
                            end else begin
                                d_rd  <= '0;
                                state <= S_DONE;
                            end
                        end
                        default: begin
                            error <= 1'b1;
                            d_rd  <= '0;
                            state <= S_DONE;
                        end
                    endcase
                end

                S_WAIT_HALT: begin
                    if (cpu_halted) begin
                        d_rd  <= '0;
                        state <= S_DONE;
                    end else if (tmo_hit) begin
                        error <= 1'b1;
                        d_rd  <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (is_write)
                            d_rd <= '0;
                        else if (is_word)
                            d_rd <= mem_rdata;
                        else
                            d_rd <= {24'd0, rd_byte};
                        state <= S_DONE;
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        error   <= 1'b1;
                        d_rd    <= '0;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_REG_RD: begin
                    d_rd  <= rf_rdata;
                    state <= S_DONE;
                end

                S_RST_HOLD: begin
                    if (cnt == CNT_W'(RESET_HOLD - 1)) begin
                        cpu_reset <= 1'b0;
                        d_rd      <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    ctrlr_busy <= 1'b0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_ctrlr.sv
// Self-checking bench for debug_ctrlr: directed steps then random commands,
// scored against a command-level model with shadow memory and register file.
module tb_debug_ctrlr;

    localparam int TMO   = 255;
    localparam int HOLD  = 4;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd = '0;
    logic [31:0] addr = '0;
    logic [31:0] d_in = '0;
    logic        out_valid = 1'b0;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic        error;
    logic        cpu_pause;
    logic        cpu_reset;
    logic        cpu_halted = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;

    debug_ctrlr #(.TIMEOUT_CYCLES(TMO), .RESET_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .addr(addr), .d_in(d_in),
        .out_valid(out_valid), .ctrlr_busy(ctrlr_busy), .d_rd(d_rd), .error(error),
        .cpu_pause(cpu_pause), .cpu_reset(cpu_reset), .cpu_halted(cpu_halted),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Bus-side storage (changed only by DUT activity) and model-side shadows.
    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] rf      [32];
    logic [31:0] ref_rf  [32];
    logic        model_pause = 1'b0;

    assign rf_rdata = rf[rf_addr];
    always @(posedge clk) if (rf_we) rf[rf_addr] <= rf_wdata;

    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    int          req_age = 0;
    int          req_count = 0;
    int          rf_we_cycles = 0;
    int          rst_cycles = 0;
    bit          proto_bad = 1'b0;
    logic [3:0]  seen_be;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        seen_we;
    logic [4:0]  seen_rf_addr;
    logic [7:0]  resp_idx;

    // Memory responder and activity monitors, all sampling on the falling edge.
    always @(negedge clk) begin
        if (rf_we) begin
            rf_we_cycles++;
            seen_rf_addr = rf_addr;
        end
        if (cpu_reset) rst_cycles++;
        if (!mem_req) begin
            req_age = 0;
            mem_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack   = 1'b0;
            proto_bad = 1'b1;
        end else begin
            if (req_age == 0) begin
                req_count++;
                seen_be    = mem_be;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
                seen_we    = mem_we;
            end else if (mem_be !== seen_be || mem_addr !== seen_addr ||
                         mem_wdata !== seen_wdata || mem_we !== seen_we) begin
                proto_bad = 1'b1;
            end
            if (ack_en && req_age == ack_delay) begin
                resp_idx  = mem_addr[9:2];
                mem_rdata = bus_mem[resp_idx];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) bus_mem[resp_idx][8*b +: 8] = mem_wdata[8*b +: 8];
                mem_ack = 1'b1;
            end
            req_age++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Command-level reference: result, timing and side effects from the command rules.
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                         input int halt_at, output logic e, output logic [31:0] rd,
                         output int busy, output int nreq, output int nrfwe, output int nrst,
                         output logic [3:0] be, output logic [31:0] wd, output logic we);
        logic [7:0] idx;
        bit word, wr;
        idx = a[9:2];
        e = 1'b0; rd = '0; busy = 2; nreq = 0; nrfwe = 0; nrst = 0;
        be = '0; wd = '0; we = 1'b0;
        word = (c == 4'h5) || (c == 4'h6);
        wr   = (c == 4'h6) || (c == 4'h8);
        case (c)
            4'h1: begin
                model_pause = 1'b1;
                if (cpu_halted)       busy = 3;
                else if (halt_at > 0) busy = halt_at + 1;
                else begin e = 1'b1; busy = TMO + 3; end
            end
            4'h2: model_pause = 1'b0;
            4'h3: rd = {30'd0, model_pause, cpu_halted};
            4'h4: begin nrst = HOLD; busy = HOLD + 2; end
            4'h5, 4'h6, 4'h7, 4'h8: begin
                if (!cpu_halted || (word && a[1:0] != 2'b00)) e = 1'b1;
                else begin
                    nreq = 1;
                    we   = wr;
                    be   = word ? 4'hF : 4'(1 << a[1:0]);
                    wd   = word ? d : {d[7:0], d[7:0], d[7:0], d[7:0]};
                    if (!ack_en) begin
                        e = 1'b1; busy = TMO + 3;
                    end else begin
                        busy = ack_delay + 3;
                        if (wr && word) ref_mem[idx] = d;
                        else if (wr)    ref_mem[idx][8*a[1:0] +: 8] = d[7:0];
                        else if (word)  rd = ref_mem[idx];
                        else            rd = (ref_mem[idx] >> (8 * a[1:0])) & 32'hFF;
                    end
                end
            end
            4'h9, 4'hA: begin
                if (!cpu_halted || a > 32'd31) e = 1'b1;
                else if (c == 4'h9) begin rd = ref_rf[a[4:0]]; busy = 3; end
                else begin nrfwe = 1; ref_rf[a[4:0]] = d; end
            end
            default: e = 1'b1;
        endcase
    endtask

    task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                       input int halt_at, input bit inject);
        logic e, we;
        logic [31:0] rd, wd;
        logic [3:0] be;
        int busy, nreq, nrfwe, nrst, n;
        model(c, a, d, halt_at, e, rd, busy, nreq, nrfwe, nrst, be, wd, we);
        req_count = 0; rf_we_cycles = 0; rst_cycles = 0; proto_bad = 1'b0;
        @(negedge clk);
        cmd = c; addr = a; d_in = d; out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        n = 0;
        while (ctrlr_busy && n < LIMIT) begin
            n++;
            if (halt_at > 0 && n == halt_at) cpu_halted = 1'b1;
            if (inject && n == 2) begin
                cmd = 4'hA; addr = 32'd1; d_in = 32'h1234_5678; out_valid = 1'b1;
            end
            if (inject && n == 3) out_valid = 1'b0;
            @(negedge clk);
        end
        check($sformatf("cmd%h_done", c), 32'(n < LIMIT), 32'd1);
        if (busy > 0) check($sformatf("cmd%h_busy", c), 32'(n), 32'(busy));
        check($sformatf("cmd%h_error", c), 32'(error), 32'(e));
        check($sformatf("cmd%h_d_rd", c), d_rd, rd);
        check($sformatf("cmd%h_pause", c), 32'(cpu_pause), 32'(model_pause));
        check($sformatf("cmd%h_req_n", c), 32'(req_count), 32'(nreq));
        check($sformatf("cmd%h_rf_we_n", c), 32'(rf_we_cycles), 32'(nrfwe));
        check($sformatf("cmd%h_rst_n", c), 32'(rst_cycles), 32'(nrst));
        if (nreq > 0) begin
            check("mem_be", 32'(seen_be), 32'(be));
            check("mem_wdata", seen_wdata, wd);
            check("mem_addr", seen_addr, a);
            check("mem_we", 32'(seen_we), 32'(we));
            check("mem_stable", 32'(proto_bad), 32'd0);
        end
        if (nrfwe > 0) check("rf_addr", 32'(seen_rf_addr), 32'(a[4:0]));
        if (inject) begin
            repeat (3) begin
                @(negedge clk);
                check("no_extra_cmd", 32'(ctrlr_busy), 32'd0);
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra;
        int n;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[8'h40] = '0;
        ref_mem[8'h40] = '0;
        for (int i = 0; i < 32; i++) begin
            rf[i]     = $urandom;
            ref_rf[i] = rf[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ctl", 32'({ctrlr_busy, error, cpu_pause, cpu_reset, mem_req, mem_we, rf_we}), 32'd0);
        check("rst_d_rd", d_rd, 32'd0);
        check("rst_mem", mem_addr | mem_wdata | 32'(mem_be), 32'd0);
        check("rst_rf", rf_wdata | 32'(rf_addr), 32'd0);

        run(4'h3, 32'd0, 32'd0, 0, 1'b0);                  // STATUS from reset
        run(4'h1, 32'd0, 32'd0, 3, 1'b0);                  // PAUSE, halt arrives later
        run(4'h3, 32'd0, 32'd0, 0, 1'b0);                  // STATUS -> 3
        cpu_halted = 1'b0;
        run(4'h1, 32'd0, 32'd0, 0, 1'b0);                  // PAUSE timeout
        cpu_halted = 1'b1;
        ack_delay = 1;
        run(4'h8, 32'h102, 32'hAB, 0, 1'b0);               // MEM_WR_B
        ack_delay = 2;
        run(4'h5, 32'h100, 32'd0, 0, 1'b0);                // MEM_RD_W -> 0x00AB0000
        check("rd_after_wr_b", d_rd, 32'h00AB_0000);
        run(4'h7, 32'h102, 32'd0, 0, 1'b0);                // MEM_RD_B
        run(4'h5, 32'h101, 32'd0, 0, 1'b0);                // misaligned word
        cpu_halted = 1'b0;
        run(4'h5, 32'h100, 32'd0, 0, 1'b0);                // not halted
        cpu_halted = 1'b1;
        run(4'hA, 32'd5, 32'hDEAD_BEEF, 0, 1'b0);          // REG_WR
        run(4'h9, 32'd5, 32'd0, 0, 1'b0);                  // REG_RD
        check("reg_rd_val", d_rd, 32'hDEAD_BEEF);
        run(4'h9, 32'h20, 32'd0, 0, 1'b0);                 // bad reg address
        ack_delay = 6;
        run(4'h5, 32'h104, 32'd0, 0, 1'b1);                // out_valid mid-command
        run(4'h4, 32'd0, 32'd0, 0, 1'b0);                  // CPU_RESET
        ack_en = 1'b0;
        run(4'h6, 32'h108, 32'hCAFE_F00D, 0, 1'b0);        // memory timeout
        ack_en = 1'b1;
        run(4'h2, 32'd0, 32'd0, 0, 1'b0);                  // RESUME
        run(4'h0, 32'd0, 32'd0, 0, 1'b0);                  // illegal codes
        run(4'hC, 32'd0, 32'd0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rc = 4'($urandom_range(0, 15));
            cpu_halted = ($urandom_range(0, 7) != 0);
            ack_delay = $urandom_range(0, 4);
            if (rc == 4'h9 || rc == 4'hA)
                ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 31));
            else
                ra = 32'($urandom_range(0, 1023));
            run(rc, ra, $urandom, 0, 1'b0);
        end

        // Async reset while a memory request is outstanding
        cpu_halted = 1'b1;
        run(4'h1, 32'd0, 32'd0, 0, 1'b0);
        ack_en = 1'b0;
        @(negedge clk);
        cmd = 4'h5; addr = 32'h10; out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("req_before_reset", 32'(mem_req), 32'd1);
        #5 reset = 1'b1;
        #1;
        check("async_mem_req", 32'(mem_req), 32'd0);
        check("async_busy", 32'(ctrlr_busy), 32'd0);
        check("async_pause", 32'(cpu_pause), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_pause = 1'b0;
        ack_en = 1'b1;
        ack_delay = 0;
        run(4'h3, 32'd0, 32'd0, 0, 1'b0);
        run(4'h5, 32'h100, 32'd0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_ctrlr.md
Name: debug_ctrlr

Overview:
Command executor sitting directly downstream of the `serial` UART front end. It consumes the decoded `cmd`/`addr`/`d_in` triple on `out_valid` and executes it against the RISC-V core: pause/resume/reset, memory word/byte access and register-file access. It returns `ctrlr_busy`, `d_rd` and `error` to `serial`, which transmits the reply.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for `cpu_halted` or `mem_ack` before aborting with `error`.
RESET_HOLD, 4, number of cycles `cpu_reset` is held high for a CPU_RESET command.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
cmd  in  4  command code from serial
addr  in  32  command address
d_in  in  32  command write data
out_valid  in  1  single-cycle strobe: cmd/addr/d_in valid
ctrlr_busy  out  1  command in progress
d_rd  out  32  read result
error  out  1  last command failed
cpu_pause  out  1  pause request to core (sticky)
cpu_reset  out  1  core reset pulse
cpu_halted  in  1  core has stopped at an instruction boundary
mem_req  out  1  memory request
mem_we  out  1  write enable (qualified by mem_req)
mem_be  out  4  byte enables
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single cycle
rf_addr  out  5  register-file address
rf_we  out  1  register-file write enable
rf_wdata  out  32  register-file write data
rf_rdata  in  32  register-file read data, combinational from rf_addr

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset takes effect immediately and can occur mid-command; `mem_req`, `rf_we` and `cpu_reset` drop asynchronously.
- States: IDLE, EXEC, WAIT_HALT, MEM_WAIT, REG_RD, RST_HOLD, DONE.
- IDLE: on `out_valid`, latch `cmd`/`addr`/`d_in`, clear `error`, go to EXEC. `ctrlr_busy` is registered and rises in the cycle after `out_valid`. `out_valid` is ignored whenever state is not IDLE.
- `ctrlr_busy` = 1 in every state except IDLE.
- `d_rd` and `error` are updated on entry to DONE and held until the next accepted command. DONE lasts 1 cycle, then the block returns to IDLE; `ctrlr_busy` falls in the cycle after DONE.
- Command codes:
  - 0x1 PAUSE: set `cpu_pause` and go to WAIT_HALT. If `cpu_halted` is seen within TIMEOUT_CYCLES, go to DONE. Otherwise set `error` = 1 and go to DONE; `cpu_pause` stays 1.
  - 0x2 RESUME: clear `cpu_pause`, then DONE.
  - 0x3 STATUS: `d_rd` = {30'b0, `cpu_pause`, `cpu_halted`}, then DONE.
  - 0x4 CPU_RESET: `cpu_reset` = 1 for exactly RESET_HOLD cycles (RST_HOLD), then DONE. `cpu_pause` is unchanged.
  - 0x5 MEM_RD_W / 0x6 MEM_WR_W: `mem_be` = 4'hF, `mem_wdata` = `d_in`.
    - `addr[1:0]` != 0 → `error`, no bus cycle.
  - 0x7 MEM_RD_B / 0x8 MEM_WR_B:
    - `mem_be` = 1 << `addr[1:0]`.
    - `mem_wdata` = {4{`d_in[7:0]`}}.
    - Read result = selected byte of `mem_rdata`, zero-extended.
  - 0x9 REG_RD / 0xA REG_WR: `rf_addr` = `addr[4:0]`.
    - `addr[31:5]` != 0 → `error`.
    - REG_WR: `rf_we` high for exactly 1 cycle in EXEC with `rf_wdata` = `d_in`.
    - REG_RD: `rf_addr` is driven in EXEC; `rf_rdata` is captured in REG_RD, the next cycle.
  - All other codes (0x0, 0xB–0xF): `error` = 1, `d_rd` = 0, no side effects.
- Memory and register commands require `cpu_halted` = 1 in EXEC. If it is 0: `error` = 1, no bus or RF activity, go to DONE.
- Memory transaction:
  - `mem_addr` = `addr`. `mem_req` rises in the first cycle of MEM_WAIT and stays high through the `mem_ack` cycle inclusive; it is 0 the cycle after.
  - `mem_we`/`mem_be`/`mem_addr`/`mem_wdata` are stable while `mem_req` = 1.
  - Read data is captured on the `mem_ack` cycle.
  - No ack within TIMEOUT_CYCLES: drop `mem_req`, `error` = 1, `d_rd` = 0, go to DONE.
- Timeout counter: 8+ bits wide, cleared on entering WAIT_HALT or MEM_WAIT. It expires when count == TIMEOUT_CYCLES with the awaited input still low. An awaited input arriving on the expiry cycle counts as success.
- Write commands leave `d_rd` = 0.

Test Plan:
- Reset held, then released → all outputs 0, `ctrlr_busy` = 0. STATUS → `d_rd` = 0x0, busy high for exactly 2 cycles (EXEC, DONE).
- PAUSE with `cpu_halted` asserted 3 cycles later → `cpu_pause` = 1, `error` = 0. STATUS → `d_rd` = 0x3. PAUSE with `cpu_halted` stuck at 0 → `error` = 1 after 255 cycles, `cpu_pause` still 1.
- Core halted, MEM_WR_B `addr` = 0x102, `d_in` = 0xAB → `mem_be` = 4'b0100, `mem_wdata` = 0xABABABAB, `mem_we` = 1. Then MEM_RD_W 0x100 with `mem_rdata` = 0x00AB0000 acked after 2 cycles → `d_rd` = 0x00AB0000.
- MEM_RD_W `addr` = 0x101 → `error` = 1, `mem_req` never asserted. MEM_RD_W while `cpu_halted` = 0 → `error` = 1.
- REG_WR `addr` = 5, `d_in` = 0xDEADBEEF → single `rf_we` pulse, `rf_addr` = 5. REG_RD `addr` = 5 → `d_rd` = 0xDEADBEEF. REG_RD `addr` = 0x20 → `error` = 1.
- Async reset asserted while `mem_req` = 1 → `mem_req` = 0 immediately, state IDLE, `cpu_pause` = 0. A second `out_valid` pulsed mid-command is ignored (no extra command executes).
